// File: rtl/dmem_responder_pkg.sv
// Load/store type codes, access sizes, strobe masks and FSM states shared by the dmem responder.
package dmem_responder_pkg;

    typedef enum logic [3:0] {
        LS_LB  = 4'b0000,
        LS_LH  = 4'b0010,
        LS_LW  = 4'b0100,
        LS_LBU = 4'b1000,
        LS_LHU = 4'b1010,
        LS_SB  = 4'b0001,
        LS_SH  = 4'b0011,
        LS_SW  = 4'b0101
    } ls_type_e;

    // Field positions inside a load/store code: bit 0 marks a store, bits 2:1 give the size.
    localparam int LS_STORE_BIT = 0;
    localparam int LS_SIZE_HI   = 2;
    localparam int LS_SIZE_LO   = 1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    function automatic logic ls_valid(input logic [3:0] ls_type);
        case (ls_type)
            LS_LB, LS_LH, LS_LW, LS_LBU, LS_LHU, LS_SB, LS_SH, LS_SW: ls_valid = 1'b1;
            default:                                                  ls_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] strobe_base(input logic [1:0] size);
        case (size)
            SZ_BYTE: strobe_base = STRB_BYTE;
            SZ_HALF: strobe_base = STRB_HALF;
            default: strobe_base = STRB_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the memory stage (master) and the data memory (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_ls_type;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_ls_type, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_ls_type, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store strobes/data replication and load right-justification.
// DMEM_MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of forcing the offset aligned.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [3:0]  ls_type_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  strobe_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_shifted_o,
    output logic        misaligned_o
);

    logic [1:0] size;
    logic [1:0] eff_off;
    logic       is_store;
    logic       valid;

    // NOTE: every output of this block gets a default before any branch, so no latches are inferred.
    always_comb begin
        size     = ls_type_i[LS_SIZE_HI:LS_SIZE_LO];
        is_store = ls_type_i[LS_STORE_BIT];
        valid    = ls_valid(ls_type_i);
        eff_off  = off_i;
        misaligned_o = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned_o = valid && (((size == SZ_HALF) && off_i[0]) ||
                                 ((size == SZ_WORD) && (off_i != 2'b00)));
`else
        case (size)
            SZ_HALF: eff_off = {off_i[1], 1'b0};
            SZ_WORD: eff_off = 2'b00;
            default: eff_off = off_i;
        endcase
`endif

        strobe_o = 4'b0000;
        if (valid && is_store && !misaligned_o) begin
            strobe_o = strobe_base(size) << eff_off;
        end

        case (size)
            SZ_BYTE: wword_o = {4{wdata_i[7:0]}};
            SZ_HALF: wword_o = {2{wdata_i[15:0]}};
            default: wword_o = wdata_i;
        endcase

        rdata_shifted_o = rword_i >> {eff_off, 3'b000};
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder top: request latch, IDLE/BUSY/RESP FSM with wait counter, and the word array.
// Misaligned handling follows DMEM_MISALIGN_TRAP_EN as resolved in dmem_lane_align.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned WAIT_CYC = 1
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [3:0]        ls_q, ls_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              commit;

    logic [ADDR_W+1:0] acc_addr;
    logic [3:0]        acc_ls;
    logic [31:0]       acc_wdata;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rword;
    logic [3:0]        strobe;
    logic [31:0]       wword;
    logic [31:0]       rdata_shifted;
    logic              misaligned;
    logic              load_ok;
    logic              unused_addr;

    logic [31:0] mem [2**ADDR_W];

    // With no wait cycles the access happens on the accept edge, so it reads straight off the bus.
    assign acc_addr  = (state_q == ST_IDLE) ? bus.req_addr[ADDR_W+1:0] : addr_q;
    assign acc_ls    = (state_q == ST_IDLE) ? bus.req_ls_type : ls_q;
    assign acc_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
    assign idx       = acc_addr[ADDR_W+1:2];
    assign rword     = mem[idx];
    assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

    dmem_lane_align u_align (
        .ls_type_i       (acc_ls),
        .off_i           (acc_addr[1:0]),
        .wdata_i         (acc_wdata),
        .rword_i         (rword),
        .strobe_o        (strobe),
        .wword_o         (wword),
        .rdata_shifted_o (rdata_shifted),
        .misaligned_o    (misaligned)
    );

    assign load_ok = ls_valid(acc_ls) && !acc_ls[LS_STORE_BIT] && !misaligned;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ls_d    = ls_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr[ADDR_W+1:0];
                    ls_d    = bus.req_ls_type;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'd0;
                    if (WAIT_CYC == 0) begin
                        commit  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == WAIT_LAST) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            rdata_d = load_ok ? rdata_shifted : 32'd0;
            err_d   = misaligned;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            ls_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ls_q    <= ls_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array is deliberately not reset; a reset only blocks a commit landing on the same edge.
    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) begin
                    mem[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYC=1, ADDR_W=10); trap build selected by DMEM_MISALIGN_TRAP_EN.
module tb_dmem_responder;

    localparam int WAIT = 1;

    localparam logic [3:0] LB  = 4'b0000;
    localparam logic [3:0] LH  = 4'b0010;
    localparam logic [3:0] LW  = 4'b0100;
    localparam logic [3:0] LBU = 4'b1000;
    localparam logic [3:0] LHU = 4'b1010;
    localparam logic [3:0] SB  = 4'b0001;
    localparam logic [3:0] SH  = 4'b0011;
    localparam logic [3:0] SW  = 4'b0101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    dmem_responder_if bus ();

    dmem_responder #(.ADDR_W(10), .WAIT_CYC(WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Issues one request and returns the response seen once rsp_valid rises; lat = edges after accept, -1 on timeout.
    task automatic do_req(input logic [3:0] ls, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [32:0] rsp, output int lat);
        int n;
        lat = -1;
        rsp = 'x;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid   = 1'b1;
        bus.req_ls_type = ls;
        bus.req_addr    = addr;
        bus.req_wdata   = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.rsp_valid) begin
            lat = n;
            rsp = {bus.rsp_err, bus.rsp_rdata};
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset req_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'd0) begin failures++; $display("FAIL reset rsp_rdata: got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL reset rsp_err: got %b want 0", bus.rsp_err); end
    endtask

    task automatic test_word();
        logic [32:0] r;
        int lat;
        do_req(SW, 32'h10, 32'hDEADBEEF, r, lat);
        checks++; if (r !== 33'h0_00000000) begin failures++; $display("FAIL sw_10 rsp: got %h want 0_00000000", r); end
        checks++; if (lat !== WAIT) begin failures++; $display("FAIL sw_10 latency: got %0d want %0d", lat, WAIT); end
        do_req(LW, 32'h10, 32'h0, r, lat);
        checks++; if (r !== 33'h0_DEADBEEF) begin failures++; $display("FAIL lw_10 rsp: got %h want 0_deadbeef", r); end
        checks++; if (lat !== WAIT) begin failures++; $display("FAIL lw_10 latency: got %0d want %0d", lat, WAIT); end
    endtask

    task automatic test_byte();
        logic [32:0] r;
        int lat;
        do_req(SW, 32'h10, 32'h11223344, r, lat);
        do_req(SB, 32'h13, 32'h000000AA, r, lat);
        checks++; if (r !== 33'h0_00000000) begin failures++; $display("FAIL sb_13 rsp: got %h want 0_00000000", r); end
        do_req(LW, 32'h10, 32'h0, r, lat);
        checks++; if (r !== 33'h0_AA223344) begin failures++; $display("FAIL sb_merge word: got %h want 0_aa223344", r); end
        do_req(LB, 32'h13, 32'h0, r, lat);
        checks++; if (r !== 33'h0_000000AA) begin failures++; $display("FAIL lb_13 rsp: got %h want 0_000000aa", r); end
        do_req(LBU, 32'h11, 32'h0, r, lat);
        checks++; if (r !== 33'h0_00AA2233) begin failures++; $display("FAIL lbu_11 rsp: got %h want 0_00aa2233", r); end
    endtask

    task automatic test_half();
        logic [32:0] r;
        int lat;
        do_req(SW, 32'h10, 32'h00000000, r, lat);
        do_req(SH, 32'h12, 32'h0000BEEF, r, lat);
        do_req(LW, 32'h10, 32'h0, r, lat);
        checks++; if (r !== 33'h0_BEEF0000) begin failures++; $display("FAIL sh_merge word: got %h want 0_beef0000", r); end
        do_req(LHU, 32'h12, 32'h0, r, lat);
        checks++; if (r !== 33'h0_0000BEEF) begin failures++; $display("FAIL lhu_12 rsp: got %h want 0_0000beef", r); end
        do_req(LH, 32'h10, 32'h0, r, lat);
        checks++; if (r !== 33'h0_BEEF0000) begin failures++; $display("FAIL lh_10 raw: got %h want 0_beef0000", r); end
    endtask

    task automatic test_misaligned();
        logic [32:0] r;
        int lat;
`ifdef DMEM_MISALIGN_TRAP_EN
        localparam logic [32:0] EXP_LW11  = 33'h1_00000000;
        localparam logic [32:0] EXP_SH13  = 33'h1_00000000;
        localparam logic [32:0] EXP_WORD  = 33'h0_BEEF0000;
        localparam logic [32:0] EXP_LBU11 = 33'h0_00BEEF00;
`else
        localparam logic [32:0] EXP_LW11  = 33'h0_BEEF0000;
        localparam logic [32:0] EXP_SH13  = 33'h0_00000000;
        localparam logic [32:0] EXP_WORD  = 33'h0_12340000;
        localparam logic [32:0] EXP_LBU11 = 33'h0_00123400;
`endif
        do_req(LW, 32'h11, 32'h0, r, lat);
        checks++; if (r !== EXP_LW11) begin failures++; $display("FAIL lw_11 rsp: got %h want %h", r, EXP_LW11); end
        checks++; if (lat !== WAIT) begin failures++; $display("FAIL lw_11 latency: got %0d want %0d", lat, WAIT); end
        do_req(SH, 32'h13, 32'h00001234, r, lat);
        checks++; if (r !== EXP_SH13) begin failures++; $display("FAIL sh_13 rsp: got %h want %h", r, EXP_SH13); end
        do_req(LW, 32'h10, 32'h0, r, lat);
        checks++; if (r !== EXP_WORD) begin failures++; $display("FAIL sh_13 word: got %h want %h", r, EXP_WORD); end
        do_req(LBU, 32'h11, 32'h0, r, lat);
        checks++; if (r !== EXP_LBU11) begin failures++; $display("FAIL lbu_11 rsp: got %h want %h", r, EXP_LBU11); end
    endtask

    task automatic test_noop();
        logic [32:0] r;
        int lat;
        logic [3:0] bad [3] = '{4'b0110, 4'b0111, 4'b1111};
        do_req(SW, 32'h10, 32'h55667788, r, lat);
        for (int i = 0; i < 3; i++) begin
            do_req(bad[i], 32'h10, 32'hFFFFFFFF, r, lat);
            checks++; if (r !== 33'h0_00000000) begin failures++; $display("FAIL noop_%0d rsp: got %h want 0_00000000", i, r); end
            checks++; if (lat !== WAIT) begin failures++; $display("FAIL noop_%0d latency: got %0d want %0d", i, lat, WAIT); end
        end
        do_req(LW, 32'h10, 32'h0, r, lat);
        checks++; if (r !== 33'h0_55667788) begin failures++; $display("FAIL noop word: got %h want 0_55667788", r); end
    endtask

    task automatic test_wrap();
        logic [32:0] r;
        int lat;
        do_req(SW, 32'h80001010, 32'hCAFEF00D, r, lat);
        do_req(LW, 32'h10, 32'h0, r, lat);
        checks++; if (r !== 33'h0_CAFEF00D) begin failures++; $display("FAIL wrap lw_10: got %h want 0_cafef00d", r); end
        do_req(LW, 32'h00001010, 32'h0, r, lat);
        checks++; if (r !== 33'h0_CAFEF00D) begin failures++; $display("FAIL wrap lw_1010: got %h want 0_cafef00d", r); end
    endtask

    task automatic test_hold();
        logic [32:0] r;
        int lat;
        bus.rsp_ready = 1'b0;
        do_req(LW, 32'h10, 32'h0, r, lat);
        checks++; if (r !== 33'h0_CAFEF00D) begin failures++; $display("FAIL hold rsp: got %h want 0_cafef00d", r); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'hCAFEF00D}) begin
                failures++;
                $display("FAIL hold cycle %0d: got valid=%b ready=%b err=%b rdata=%h want 1 0 0 cafef00d",
                         i, bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_rdata);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin failures++; $display("FAIL hold release: got valid=%b ready=%b want 0 1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int rsp = 0;
        int n;
        bus.req_valid   = 1'b1;
        bus.req_ls_type = LW;
        bus.req_addr    = 32'h10;
        bus.req_wdata   = 32'h0;
        for (int i = 0; i < 12; i++) begin
            if (bus.req_ready) acc++;
            if (bus.rsp_valid) begin
                rsp++;
                checks++; if (bus.rsp_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b rdata: got %h want cafef00d", bus.rsp_rdata); end
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        // Interval WAIT+2 = 3: accepts at cycles 0,3,6,9 and responses at 2,5,8,11.
        checks++; if (acc !== 4) begin failures++; $display("FAIL b2b accepts: got %0d want 4", acc); end
        checks++; if (rsp !== 4) begin failures++; $display("FAIL b2b responses: got %0d want 4", rsp); end
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] r;
        int lat;
        do_req(SW, 32'h20, 32'h01020304, r, lat);
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_ls_type = SW;
        bus.req_addr    = 32'h20;
        bus.req_wdata   = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if ({bus.req_ready, bus.rsp_valid} !== 2'b00) begin failures++; $display("FAIL mid busy: got ready=%b valid=%b want 0 0", bus.req_ready, bus.rsp_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL mid reset outputs: got ready=%b valid=%b err=%b rdata=%h want 1 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        do_req(LW, 32'h20, 32'h0, r, lat);
        checks++; if (r !== 33'h0_01020304) begin failures++; $display("FAIL mid discarded store: got %h want 0_01020304", r); end

        bus.rsp_ready = 1'b0;
        do_req(LW, 32'h20, 32'h0, r, lat);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b0, 32'd0}) begin failures++; $display("FAIL resp dropped: got valid=%b rdata=%h want 0 0", bus.rsp_valid, bus.rsp_rdata); end
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_ls_type = 4'b0000;
        bus.req_addr    = 32'h0;
        bus.req_wdata   = 32'h0;
        bus.rsp_ready   = 1'b1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_noop();
        test_wrap();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
